// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline register and the writeback datapath that feeds the
//   register file. It captures the MEM-stage results and selects either the
//   ALU result or the load data. It also provides stall/flush control and a
//   counter of retired instructions.
//
// Configuration macro: WB_LOAD_EXT_EN
//   defined   : sub-word loads (lh/lhu/lb/lbu) are selected from the
//               big-endian memory word and sign/zero extended.
//   undefined : mem_loadType is ignored and not registered; a load always
//               returns the full readData word.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   mem_valid .. mem_readData MEM-stage results to capture
//   wb_stall / wb_flush       hold / invalidate the WB contents (flush wins)
//   writeData/writeReg/regWrite  register_file write port
//   wb_valid                  WB holds a valid instruction
//   retire_count              instructions retired since reset (wraps)
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_regWrite,
  input  logic              mem_memToReg,
  input  logic [2:0]        mem_loadType,
  input  logic [4:0]        mem_writeReg,
  input  logic [DATA_W-1:0] mem_aluResult,
  input  logic [DATA_W-1:0] mem_readData,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic [DATA_W-1:0] writeData,
  output logic [4:0]        writeReg,
  output logic              regWrite,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retire_count
);

  logic              valid_reg;
  logic              regwrite_reg;
  logic              memtoreg_reg;
  logic [4:0]        writereg_reg;
  logic [DATA_W-1:0] aluresult_reg;
  logic [DATA_W-1:0] readdata_reg;
  logic [CNT_W-1:0]  retire_count_reg;
  logic [DATA_W-1:0] load_value;

  // Stage register. Priority: reset, flush, stall, capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      regwrite_reg  <= 1'b0;
      memtoreg_reg  <= 1'b0;
      writereg_reg  <= '0;
      aluresult_reg <= '0;
      readdata_reg  <= '0;
    end else if (wb_flush) begin
      valid_reg     <= 1'b0;
      regwrite_reg  <= 1'b0;
      memtoreg_reg  <= 1'b0;
      writereg_reg  <= '0;
      aluresult_reg <= '0;
      readdata_reg  <= '0;
    end else if (!wb_stall) begin
      valid_reg     <= mem_valid;
      regwrite_reg  <= mem_regWrite;
      memtoreg_reg  <= mem_memToReg;
      writereg_reg  <= mem_writeReg;
      aluresult_reg <= mem_aluResult;
      readdata_reg  <= mem_readData;
    end
  end

  // An instruction retires on the edge where it leaves WB normally; a
  // stalled one is counted only once, when the stall finally drops, and a
  // flushed or reset one is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count_reg <= '0;
    end else if (valid_reg && !wb_stall && !wb_flush) begin
      retire_count_reg <= retire_count_reg + 1'b1;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0] loadtype_reg;
  logic [7:0] byte_lane [4];
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  always_ff @(posedge clk) begin
    if (rst || wb_flush) begin
      loadtype_reg <= '0;
    end else if (!wb_stall) begin
      loadtype_reg <= mem_loadType;
    end
  end

  // Big-endian lanes: lane 0 is the most significant byte of the word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lane[gi] = readdata_reg[31-8*gi -: 8];
  end

  assign byte_sel = byte_lane[aluresult_reg[1:0]];
  // Halfword uses offset[1] only; offset[0] of a misaligned lh is ignored.
  assign half_sel = aluresult_reg[1] ? readdata_reg[15:0] : readdata_reg[31:16];

  always_comb begin
    load_value = readdata_reg;
    case (loadtype_reg)
      3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_value = {16'h0000, half_sel};
      3'b011:  load_value = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_value = {24'h000000, byte_sel};
      default: load_value = readdata_reg;
    endcase
  end
`else
  // Load type has no effect in this build.
  logic unused_load_type;
  assign unused_load_type = ^mem_loadType;
  assign load_value = readdata_reg;
`endif

  assign writeData    = memtoreg_reg ? load_value : aluresult_reg;
  assign writeReg     = writereg_reg;
  // $0 is hardwired to zero, so a write to it is never presented.
  assign regWrite     = valid_reg & regwrite_reg & (writereg_reg != 5'd0);
  assign wb_valid     = valid_reg;
  assign retire_count = retire_count_reg;

endmodule
